// File: rtl/qdma_stm_h2c_pkt_gen.sv
// ---------------------------------------------------------------------------
// qdma_stm_h2c_pkt_gen
//
// Streaming H2C packet generator. It feeds the ST loopback input stream. A
// run sends cfg_num_pkts packets. Each packet is one header beat followed by
// ceil(cfg_pld_len / BYTES) payload beats. The payload is a 32-bit
// incrementing pattern starting at cfg_seed, so the C2H side can check the
// looped-back data.
//
// Build option:
//   QDMA_STM_GEN_PKT_GAP_EN  when defined, the packet-boundary state waits a
//                            further cfg_gap cycles with tvalid=0 before the
//                            next header. When undefined, cfg_gap is ignored.
//
// Header beat layout (h2c_stub_hdr_beat_t; all bits not listed are zero):
//   [10:0]                    qid
//   [23:16]                   flow_id
//   [32 +: TDEST_BITS]        tdest
//   [64 +: LEN_BITS]          cdh_slot_0.tmh.pld_len
//   [64 + LEN_BITS]           cdh_slot_0.tmh.eot (always 1)
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   start                     pulse that begins a run (ignored while busy)
//   cfg_*                     run configuration, sampled on the start cycle
//   out_axis_*                AXI-Stream master (tuser=1 marks a header beat)
//   busy                      run in progress (cycle after start .. DONE)
//   done                      single-cycle pulse in the DONE state
//   pkt_cnt                   packets whose tlast beat was accepted this run
//   dbg_state                 current FSM state encoding, for checkers
//
// Handshake: a beat transfers on a rising edge where out_axis_tvalid and
// out_axis_tready are both 1. Once tvalid is 1, tdata/tuser/tlast/tdest hold
// their values and tvalid stays 1 until that transfer happens. tready may
// change freely and never combinationally affects any output.
// ---------------------------------------------------------------------------
module qdma_stm_h2c_pkt_gen #(
  parameter int MAX_DATA_WIDTH = 512,
  parameter int TDEST_BITS     = 16,
  parameter int LEN_BITS       = 16,
  parameter int TCQ            = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [10:0]               cfg_qid,
  input  logic [7:0]                cfg_flow_id,
  input  logic [TDEST_BITS-1:0]     cfg_tdest,
  input  logic [LEN_BITS-1:0]       cfg_pld_len,
  input  logic [15:0]               cfg_num_pkts,
  input  logic [31:0]               cfg_seed,
  input  logic [7:0]                cfg_gap,
  output logic [MAX_DATA_WIDTH-1:0] out_axis_tdata,
  output logic                      out_axis_tvalid,
  output logic [TDEST_BITS-1:0]     out_axis_tdest,
  output logic                      out_axis_tuser,
  output logic                      out_axis_tlast,
  input  logic                      out_axis_tready,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               pkt_cnt,
  output logic [2:0]                dbg_state
);

  localparam int BYTES = MAX_DATA_WIDTH / 8;
  localparam int WORDS = MAX_DATA_WIDTH / 32;
  localparam logic [LEN_BITS:0] BYTES_L = (LEN_BITS + 1)'(BYTES);
  localparam logic [31:0]       WORDS_L = 32'(WORDS);

  localparam int QID_LSB   = 0;
  localparam int FLOW_LSB  = 16;
  localparam int TDEST_LSB = 32;
  localparam int PLEN_LSB  = 64;
  localparam int EOT_BIT   = PLEN_LSB + LEN_BITS;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PLD  = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                state;
  logic [10:0]           lat_qid;
  logic [7:0]            lat_flow_id;
  logic [LEN_BITS-1:0]   lat_pld_len;
  logic [31:0]           lat_seed;
  logic [15:0]           pkts_left;   // packets not yet fully accepted
  logic [LEN_BITS:0]     rem;         // payload bytes from the presented beat on
  logic [31:0]           word_k;      // packet word index of the next beat's lane 0
  logic [LEN_BITS:0]     rem_nxt;
  logic [LEN_BITS:0]     len_ext;
  logic                  accept;

`ifdef QDMA_STM_GEN_PKT_GAP_EN
  logic [7:0]            lat_gap;
  logic [7:0]            gap_cnt;
`else
  logic                  unused_gap;
  assign unused_gap = ^cfg_gap;
`endif

  logic unused_tcq;
  assign unused_tcq = (TCQ != 0);

  assign accept    = out_axis_tvalid & out_axis_tready;
  assign rem_nxt   = rem - BYTES_L;
  assign len_ext   = {1'b0, lat_pld_len};
  assign dbg_state = state;

  function automatic logic [MAX_DATA_WIDTH-1:0] build_hdr(
    input logic [10:0]           qid,
    input logic [7:0]            flow_id,
    input logic [TDEST_BITS-1:0] tdest,
    input logic [LEN_BITS-1:0]   pld_len
  );
    logic [MAX_DATA_WIDTH-1:0] h;
    h = '0;
    h[QID_LSB +: 11]           = qid;
    h[FLOW_LSB +: 8]           = flow_id;
    h[TDEST_LSB +: TDEST_BITS] = tdest;
    h[PLEN_LSB +: LEN_BITS]    = pld_len;
    h[EOT_BIT]                 = 1'b1;
    return h;
  endfunction

  // Lane i carries base+i. Bytes at or beyond 'bytes' (the count of payload
  // bytes remaining from this beat on) are zeroed, which only bites on the
  // final beat.
  function automatic logic [MAX_DATA_WIDTH-1:0] build_pld(
    input logic [31:0]       base,
    input logic [LEN_BITS:0] bytes
  );
    logic [MAX_DATA_WIDTH-1:0] d;
    logic [31:0]               w;
    d = '0;
    for (int i = 0; i < WORDS; i++) begin
      w = base + 32'(i);
      for (int b = 0; b < 4; b++) begin
        if ((LEN_BITS + 1)'(i * 4 + b) < bytes) begin
          d[i * 32 + b * 8 +: 8] = w[b * 8 +: 8];
        end
      end
    end
    return d;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      lat_qid         <= '0;
      lat_flow_id     <= '0;
      lat_pld_len     <= '0;
      lat_seed        <= '0;
      pkts_left       <= '0;
      rem             <= '0;
      word_k          <= '0;
      out_axis_tdata  <= '0;
      out_axis_tvalid <= 1'b0;
      out_axis_tdest  <= '0;
      out_axis_tuser  <= 1'b0;
      out_axis_tlast  <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pkt_cnt         <= '0;
`ifdef QDMA_STM_GEN_PKT_GAP_EN
      lat_gap         <= '0;
      gap_cnt         <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lat_qid        <= cfg_qid;
            lat_flow_id    <= cfg_flow_id;
            lat_pld_len    <= cfg_pld_len;
            lat_seed       <= cfg_seed;
            out_axis_tdest <= cfg_tdest;
            pkts_left      <= cfg_num_pkts;
            pkt_cnt        <= '0;
            busy           <= 1'b1;
`ifdef QDMA_STM_GEN_PKT_GAP_EN
            lat_gap        <= cfg_gap;
            gap_cnt        <= '0;
`endif
            if (cfg_num_pkts == 16'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state           <= S_HDR;
              out_axis_tvalid <= 1'b1;
              out_axis_tdata  <= build_hdr(cfg_qid, cfg_flow_id, cfg_tdest, cfg_pld_len);
              out_axis_tuser  <= 1'b1;
              out_axis_tlast  <= (cfg_pld_len == '0);
            end
          end
        end

        S_HDR: begin
          if (accept) begin
            if (lat_pld_len == '0) begin
              // Header-only packet: this beat carried tlast.
              state           <= S_NEXT;
              out_axis_tvalid <= 1'b0;
              out_axis_tuser  <= 1'b0;
              out_axis_tlast  <= 1'b0;
              pkts_left       <= pkts_left - 16'd1;
              if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 32'd1;
            end else begin
              // First payload beat follows with no bubble.
              state          <= S_PLD;
              out_axis_tdata <= build_pld(lat_seed, len_ext);
              out_axis_tuser <= 1'b0;
              out_axis_tlast <= (len_ext <= BYTES_L);
              rem            <= len_ext;
              word_k         <= WORDS_L;
            end
          end
        end

        S_PLD: begin
          if (accept) begin
            if (out_axis_tlast) begin
              state           <= S_NEXT;
              out_axis_tvalid <= 1'b0;
              out_axis_tlast  <= 1'b0;
              pkts_left       <= pkts_left - 16'd1;
              if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 32'd1;
            end else begin
              out_axis_tdata <= build_pld(lat_seed + word_k, rem_nxt);
              out_axis_tlast <= (rem_nxt <= BYTES_L);
              rem            <= rem_nxt;
              word_k         <= word_k + WORDS_L;
            end
          end
        end

        S_NEXT: begin
          if (pkts_left == 16'd0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
`ifdef QDMA_STM_GEN_PKT_GAP_EN
            if (gap_cnt != lat_gap) begin
              gap_cnt <= gap_cnt + 8'd1;
            end else begin
              gap_cnt         <= '0;
              state           <= S_HDR;
              out_axis_tvalid <= 1'b1;
              out_axis_tdata  <= build_hdr(lat_qid, lat_flow_id, out_axis_tdest, lat_pld_len);
              out_axis_tuser  <= 1'b1;
              out_axis_tlast  <= (lat_pld_len == '0);
            end
`else
            state           <= S_HDR;
            out_axis_tvalid <= 1'b1;
            out_axis_tdata  <= build_hdr(lat_qid, lat_flow_id, out_axis_tdest, lat_pld_len);
            out_axis_tuser  <= 1'b1;
            out_axis_tlast  <= (lat_pld_len == '0);
`endif
          end
        end

        S_DONE: begin
          // A start seen here is deliberately dropped.
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state           <= S_IDLE;
          out_axis_tvalid <= 1'b0;
          busy            <= 1'b0;
          done            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qdma_stm_h2c_pkt_gen.sv
// ---------------------------------------------------------------------------
// tb_qdma_stm_h2c_pkt_gen
//
// Directed bench for qdma_stm_h2c_pkt_gen at MAX_DATA_WIDTH=512 (64-byte
// beats, 16 words per beat). A table of run configurations carries the
// expected done latency and packet count. A negedge monitor compares every
// accepted beat against an expected-beat queue built from the configuration,
// and checks that a stalled beat holds its values. Hand sequences cover the
// start-while-busy, start-in-DONE, reset-mid-payload and gap cases.
// ---------------------------------------------------------------------------
module tb_qdma_stm_h2c_pkt_gen;

  localparam int W = 512;
  localparam int E = W + 2;   // {tuser, tlast, tdata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start;
  logic [10:0]   cfg_qid;
  logic [7:0]    cfg_flow_id;
  logic [15:0]   cfg_tdest;
  logic [15:0]   cfg_pld_len;
  logic [15:0]   cfg_num_pkts;
  logic [31:0]   cfg_seed;
  logic [7:0]    cfg_gap;
  logic [W-1:0]  tdata;
  logic          tvalid;
  logic [15:0]   tdest;
  logic          tuser;
  logic          tlast;
  logic          tready;
  logic          busy;
  logic          done;
  logic [31:0]   pkt_cnt;
  logic [2:0]    dbg_state;

  qdma_stm_h2c_pkt_gen #(
    .MAX_DATA_WIDTH(W), .TDEST_BITS(16), .LEN_BITS(16), .TCQ(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_qid(cfg_qid), .cfg_flow_id(cfg_flow_id), .cfg_tdest(cfg_tdest),
    .cfg_pld_len(cfg_pld_len), .cfg_num_pkts(cfg_num_pkts),
    .cfg_seed(cfg_seed), .cfg_gap(cfg_gap),
    .out_axis_tdata(tdata), .out_axis_tvalid(tvalid), .out_axis_tdest(tdest),
    .out_axis_tuser(tuser), .out_axis_tlast(tlast), .out_axis_tready(tready),
    .busy(busy), .done(done), .pkt_cnt(pkt_cnt), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [E-1:0]  exp_q[$];
  logic [15:0]   exp_tdest;
  bit            rnd_ready = 1'b0;
  logic [W-1:0]  first_pld;
  logic [W-1:0]  last_pld;

  task automatic chk(input string nm, input logic [543:0] act, input logic [543:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] hdr_beat(input logic [10:0] qid, input logic [7:0] flow,
                                            input logic [15:0] td, input logic [15:0] len);
    logic [W-1:0] h;
    h = '0;
    h[10:0]  = qid;
    h[23:16] = flow;
    h[47:32] = td;
    h[79:64] = len;
    h[80]    = 1'b1;
    return h;
  endfunction

  // Expected beats for a whole run, packet by packet, byte by byte.
  task automatic build_exp(input int num, input int len, input logic [31:0] seed,
                           input logic [10:0] qid, input logic [7:0] flow, input logic [15:0] td);
    logic [W-1:0] d;
    logic [31:0]  word;
    int nb;
    nb = (len + 63) / 64;
    for (int p = 0; p < num; p++) begin
      exp_q.push_back({1'b1, (len == 0), hdr_beat(qid, flow, td, 16'(len))});
      for (int b = 0; b < nb; b++) begin
        d = '0;
        for (int w = 0; w < 16; w++) begin
          word = seed + 32'(b * 16 + w);
          for (int by = 0; by < 4; by++) begin
            if ((b * 16 + w) * 4 + by < len) d[w * 32 + by * 8 +: 8] = word[by * 8 +: 8];
          end
        end
        exp_q.push_back({1'b0, (b == nb - 1), d});
      end
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [E+15:0] prev;
    logic [E-1:0]  e;
    bit            prev_stall;
    bit            saw_hdr;
    prev_stall = 1'b0;
    saw_hdr    = 1'b0;
    prev       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        saw_hdr    = 1'b0;
      end else begin
        if (prev_stall) chk("stall_hold", {tvalid, tuser, tlast, tdest, tdata}, {1'b1, prev});
        if (tvalid && tready) begin
          chk("tdest", tdest, exp_tdest);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got tuser=%0b tlast=%0b data=%0h required no beat",
                     tuser, tlast, tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {tuser, tlast, tdata}, e);
          end
          if (tuser) saw_hdr = 1'b1;
          else begin
            if (saw_hdr) first_pld = tdata;
            saw_hdr  = 1'b0;
            last_pld = tdata;
          end
        end
        prev_stall = tvalid && !tready;
        prev       = {tuser, tlast, tdest, tdata};
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int          num;
    int          len;
    logic [31:0] seed;
    logic [10:0] qid;
    logic [7:0]  flow;
    logic [15:0] td;
    bit          rnd;       // random tready
    logic [7:0]  gap;
    bit          poke;      // start + cfg changes mid-run
    bit          sad;       // start pulse in the DONE cycle
    int          exp_cyc;   // cycles from start sample to done; 0 = not checked
    int          exp_cnt;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(int num, int len, logic [31:0] seed, logic [10:0] qid,
                              logic [7:0] flow, logic [15:0] td, bit rnd, logic [7:0] gap,
                              bit poke, bit sad, int exp_cyc, int exp_cnt);
    vec_t v;
    v.num = num; v.len = len; v.seed = seed; v.qid = qid; v.flow = flow; v.td = td;
    v.rnd = rnd; v.gap = gap; v.poke = poke; v.sad = sad;
    v.exp_cyc = exp_cyc; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    cfg_qid      = v.qid;
    cfg_flow_id  = v.flow;
    cfg_tdest    = v.td;
    cfg_pld_len  = 16'(v.len);
    cfg_num_pkts = 16'(v.num);
    cfg_seed     = v.seed;
    cfg_gap      = v.gap;
    exp_tdest    = v.td;
    build_exp(v.num, v.len, v.seed, v.qid, v.flow, v.td);
    rnd_ready = v.rnd;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    chk($sformatf("v%0d_busy_after_start", idx), busy, 1'b1);
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (v.poke && cyc == 2) begin
        start        = 1'b1;
        cfg_seed     = ~v.seed;
        cfg_num_pkts = 16'd7;
        cfg_pld_len  = 16'd0;
        cfg_tdest    = ~v.td;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL v%0d_timeout: got no done after %0d cycles required done", idx, cyc);
    end else if (v.exp_cyc > 0) begin
      chk($sformatf("v%0d_done_cycle", idx), cyc, v.exp_cyc);
    end
    chk($sformatf("v%0d_pkt_cnt", idx), pkt_cnt, v.exp_cnt);
    chk($sformatf("v%0d_busy_in_done", idx), busy, 1'b1);
    chk($sformatf("v%0d_tvalid_in_done", idx), tvalid, 1'b0);
    if (v.sad) begin
      start        = 1'b1;
      cfg_num_pkts = 16'd1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    rnd_ready = 1'b0;
    chk($sformatf("v%0d_done_pulse", idx), done, 1'b0);
    chk($sformatf("v%0d_busy_cleared", idx), busy, 1'b0);
    if (v.sad) begin
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("v%0d_start_in_done_ignored", idx), {busy, tvalid}, 2'b00);
    end
    chk($sformatf("v%0d_queue_empty", idx), exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main ----------------
  initial begin
    rst = 1'b1; start = 1'b0;
    cfg_qid = '0; cfg_flow_id = '0; cfg_tdest = '0; cfg_pld_len = '0;
    cfg_num_pkts = '0; cfg_seed = '0; cfg_gap = '0;
    exp_tdest = '0; first_pld = '0; last_pld = '0;

    //              num len  seed          qid     flow   tdest    rnd gap  pk sad cyc cnt
    vecs[0] = mk(1,  64,  32'h0000_0100, 11'h12,  8'h34, 16'hBEEF, 0, 8'd0, 0, 0, 4, 1);
    vecs[1] = mk(1,  100, 32'hA000_0000, 11'h7FF, 8'hFF, 16'h0001, 0, 8'd0, 0, 0, 5, 1);
    vecs[2] = mk(3,  0,   32'h0000_0000, 11'h3,   8'h5,  16'h0A0A, 0, 8'd0, 0, 0, 7, 3);
    vecs[3] = mk(2,  128, 32'hFFFF_FFF8, 11'h1,   8'h2,  16'h1234, 0, 8'd0, 0, 0, 9, 2);
    vecs[4] = mk(10, 200, 32'hCAFE_0000, 11'h55,  8'h66, 16'h7777, 1, 8'd0, 0, 0, 0, 10);
    vecs[5] = mk(1,  1,   32'h1122_3344, 11'h9,   8'h1,  16'h0002, 0, 8'd0, 0, 0, 4, 1);
    vecs[6] = mk(0,  64,  32'h0000_0007, 11'h4,   8'h4,  16'h0004, 0, 8'd0, 0, 1, 1, 0);
    vecs[7] = mk(2,  64,  32'h0000_0055, 11'h6,   8'h7,  16'h0808, 0, 8'd0, 1, 0, 7, 2);
`ifdef QDMA_STM_GEN_PKT_GAP_EN
    vecs[8] = mk(2,  0,   32'h0000_0000, 11'hA,   8'hB,  16'h0C0C, 0, 8'd4, 0, 0, 9, 2);
`else
    vecs[8] = mk(2,  0,   32'h0000_0000, 11'hA,   8'hB,  16'h0C0C, 0, 8'd4, 0, 0, 5, 2);
`endif
    vecs[9] = mk(1,  64,  32'h0000_0900, 11'h21,  8'h43, 16'h6565, 0, 8'd0, 0, 0, 4, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_outputs", {busy, done, tuser, tlast, tdest, pkt_cnt, dbg_state}, '0);
    chk("rst_tdata", tdata, '0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
      if (i == 0) begin
        chk("v0_lane0", first_pld[31:0], 32'h0000_0100);
        chk("v0_lane15", first_pld[511:480], 32'h0000_010F);
      end
      if (i == 1) begin
        chk("v1_beat1_word24", last_pld[287:256], 32'hA000_0018);
        chk("v1_beat1_words25_31_zero", last_pld[511:288], '0);
      end
      if (i == 5) chk("v5_single_byte", last_pld, 512'h44);
    end

    // Reset in the middle of a 10-beat payload, then a fresh run.
    cfg_qid = 11'h77; cfg_flow_id = 8'h88; cfg_tdest = 16'h9999;
    cfg_pld_len = 16'd640; cfg_num_pkts = 16'd1; cfg_seed = 32'h0; cfg_gap = 8'd0;
    exp_tdest = 16'h9999;
    build_exp(1, 640, 32'h0, 11'h77, 8'h88, 16'h9999);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tvalid", tvalid, 1'b0);
    chk("midrst_busy_done_cnt", {busy, done, pkt_cnt}, '0);
    chk("midrst_state_idle", dbg_state, 3'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_vec(vecs[9], 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
